// File: rtl/alu_pkg.sv
// Shared opcode encodings and multiply/divide sequencer state type.
package alu_pkg;

  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_AND   = 4'b0000;
  localparam logic [OPW-1:0] OP_OR    = 4'b0001;
  localparam logic [OPW-1:0] OP_NOR   = 4'b0010;
  localparam logic [OPW-1:0] OP_ADD   = 4'b0011;
  localparam logic [OPW-1:0] OP_SLT   = 4'b0100;
  localparam logic [OPW-1:0] OP_LUI   = 4'b0101;
  localparam logic [OPW-1:0] OP_SLL   = 4'b0110;
  localparam logic [OPW-1:0] OP_SRL   = 4'b0111;
  localparam logic [OPW-1:0] OP_SUB   = 4'b1000;
  localparam logic [OPW-1:0] OP_MULTU = 4'b1001;
  localparam logic [OPW-1:0] OP_DIVU  = 4'b1010;
  localparam logic [OPW-1:0] OP_MFHI  = 4'b1011;
  localparam logic [OPW-1:0] OP_MFLO  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // True for opcodes handled by the iterative multiply/divide unit.
  function automatic logic is_muldiv(input logic [OPW-1:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_mul,
  input  logic             go_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last_c,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  md_state_e        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;   // multiplicand or divisor, frozen at accept
  logic [WIDTH-1:0] acc;    // running product high half or partial remainder
  logic [WIDTH-1:0] work;   // multiplier bits or dividend/quotient bits

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_q;

  // One multiply step and one restoring-divide step computed from current state.
  always_comb begin
    mul_sum  = {1'b0, acc} + (work[0] ? {1'b0, opnd} : '0);
    mul_hi   = mul_sum[WIDTH:1];
    mul_lo   = {mul_sum[0], work[WIDTH-1:1]};
    div_sh   = {acc, work[WIDTH-1]};
    div_ok   = (div_sh >= {1'b0, opnd});
    // Only used when div_ok, where the true difference is below opnd and fits.
    div_diff = div_sh[WIDTH-1:0] - opnd;
    div_rem  = div_ok ? div_diff : div_sh[WIDTH-1:0];
    div_q    = {work[WIDTH-2:0], div_ok};
    last_c   = (state != ST_IDLE) && (cnt == CW'(1));
  end

  // Sequencer: load on accept, iterate WIDTH times, publish HI/LO on the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      opnd  <= '0;
      acc   <= '0;
      work  <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go_mul) begin
            state <= ST_MUL;
            cnt   <= CW'(WIDTH);
            opnd  <= a;
            acc   <= '0;
            work  <= b;
            busy  <= 1'b1;
          end else if (go_div) begin
            state <= ST_DIV;
            cnt   <= CW'(WIDTH);
            opnd  <= b;
            acc   <= '0;
            work  <= a;
            busy  <= 1'b1;
          end
        end
        ST_MUL: begin
          acc  <= mul_hi;
          work <= mul_lo;
          cnt  <= cnt - CW'(1);
          if (last_c) begin
            hi    <= mul_hi;
            lo    <= mul_lo;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_DIV: begin
          acc  <= div_rem;
          work <= div_q;
          cnt  <= cnt - CW'(1);
          if (last_c) begin
            hi    <= div_rem;
            lo    <= div_q;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Single-cycle ALU with registered result plus iterative MULTU/DIVU into HI/LO.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [SHW-1:0]   Shamt,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  if ((WIDTH < 8) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("alu_muldiv: WIDTH must be even and at least 8");
  end

  logic             accept_c;
  logic             md_op_c;
  logic             md_last_c;
  logic [WIDTH-1:0] result_c;

  // Request acceptance and routing to the multi-cycle unit.
  always_comb begin
    accept_c = start && !busy && !reset;
    md_op_c  = is_muldiv(ALUOperation);
  end

  // Combinational single-cycle operations.
  always_comb begin
    result_c = '0;
    case (ALUOperation)
      OP_AND:  result_c = A & B;
      OP_OR:   result_c = A | B;
      OP_NOR:  result_c = ~(A | B);
      OP_ADD:  result_c = A + B;
      OP_SLT:  result_c = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_LUI:  result_c = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  result_c = B << Shamt;
      OP_SRL:  result_c = B >> Shamt;
      OP_SUB:  result_c = A - B;
      OP_MFHI: result_c = HI;
      OP_MFLO: result_c = LO;
      default: result_c = '0;
    endcase
  end

  muldiv_unit #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .go_mul(accept_c && (ALUOperation == OP_MULTU)),
    .go_div(accept_c && (ALUOperation == OP_DIVU)),
    .a     (A),
    .b     (B),
    .busy  (busy),
    .last_c(md_last_c),
    .hi    (HI),
    .lo    (LO)
  );

  // Result/flag registers and the completion pulse for both op classes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult <= '0;
      Zero      <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= (accept_c && !md_op_c) || md_last_c;
      if (accept_c && !md_op_c) begin
        ALUResult <= result_c;
        Zero      <= (result_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Vector table plus scoreboard bench for alu_muldiv at WIDTH=32.
module tb_alu_muldiv;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_NOR   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0100;
  localparam logic [3:0] OP_LUI   = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_MFHI  = 4'b1011;
  localparam logic [3:0] OP_MFLO  = 4'b1100;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [4:0]  sh;
  logic [31:0] a, b;
  logic [31:0] res, hi, lo;
  logic        zero, busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
  } exp_t;

  exp_t sbq[$];

  logic [31:0] m_res = 32'h0;
  logic [31:0] m_hi  = 32'h0;
  logic [31:0] m_lo  = 32'h0;
  logic        m_z   = 1'b1;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ALUOperation(op),
    .Shamt       (sh),
    .A           (a),
    .B           (b),
    .ALUResult   (res),
    .Zero        (zero),
    .busy        (busy),
    .done        (done),
    .HI          (hi),
    .LO          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Scoreboard: every done pulse retires the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 expected no pending request");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result", 64'(res), 64'(e.res));
        check("zero",   64'(zero), 64'(e.z));
        check("hi",     64'(hi),  64'(e.hi));
        check("lo",     64'(lo),  64'(e.lo));
      end
    end
  end

  // Drive one request, push its expectation, and time its completion.
  task automatic issue(input logic [3:0] o, input logic [4:0] s,
                       input logic [31:0] ia, input logic [31:0] ib,
                       input exp_t e, input int exp_lat, input int intr_at);
    int cyc;
    int bcnt;
    @(negedge clk);
    op = o; sh = s; a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sbq.push_back(e);
    a = $urandom; b = $urandom; sh = 5'($urandom); op = 4'($urandom);
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 200) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == intr_at);
      if (cyc == intr_at) begin
        op = OP_SUB; a = 32'h0000_0010; b = 32'h0000_0003;
      end
    end
    start = 1'b0;
    check("latency",      64'(cyc),  64'(exp_lat));
    check("busy_cycles",  64'(bcnt), 64'(exp_lat));
    check("busy_at_done", 64'(busy), 64'(0));
  endtask

  task automatic single(input vec_t v);
    exp_t e;
    m_res = v.res; m_z = v.z;
    e.res = m_res; e.z = m_z; e.hi = m_hi; e.lo = m_lo;
    issue(v.op, v.sh, v.a, v.b, e, 0, -1);
  endtask

  task automatic muldiv(input logic [3:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ehi, input logic [31:0] elo, input int intr_at);
    exp_t e;
    m_hi = ehi; m_lo = elo;
    e.res = m_res; e.z = m_z; e.hi = m_hi; e.lo = m_lo;
    issue(o, 5'd0, ia, ib, e, 32, intr_at);
  endtask

  vec_t vecs[$];

  initial begin
    logic [63:0] prod;
    logic [31:0] ra, rb;
    int dcnt;

    vecs = '{
      '{OP_ADD, 5'd0,  32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b1},
      '{OP_AND, 5'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0},
      '{OP_OR,  5'd0,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0},
      '{OP_NOR, 5'd0,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0},
      '{OP_SLT, 5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
      '{OP_SLT, 5'd0,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
      '{OP_SLT, 5'd0,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0},
      '{OP_LUI, 5'd0,  32'h0000_0000, 32'hABCD_1234, 32'h1234_0000, 1'b0},
      '{OP_SLL, 5'd31, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0},
      '{OP_SLL, 5'd0,  32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0},
      '{OP_SRL, 5'd31, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 1'b0},
      '{OP_SRL, 5'd4,  32'h0000_0000, 32'hF000_0000, 32'h0F00_0000, 1'b0},
      '{OP_SUB, 5'd0,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0},
      '{OP_SUB, 5'd0,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1},
      '{OP_ADD, 5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1},
      '{4'b1101, 5'd3, 32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1},
      '{OP_OR,  5'd0,  32'h0000_0000, 32'h0000_00A5, 32'h0000_00A5, 1'b0},
      '{4'b1110, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
      '{OP_MFHI, 5'd0, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1}
    };

    start = 1'b0; op = 4'd0; sh = 5'd0; a = 32'd0; b = 32'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_result", 64'(res),  64'(0));
    check("rst_zero",   64'(zero), 64'(1));
    check("rst_busy",   64'(busy), 64'(0));
    check("rst_done",   64'(done), 64'(0));
    check("rst_hi",     64'(hi),   64'(0));
    check("rst_lo",     64'(lo),   64'(0));

    foreach (vecs[i]) single(vecs[i]);

    // Multiply with carry into HI, then read both halves back.
    muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, -1);
    single('{OP_MFHI, 5'd0, 32'h0, 32'h0, 32'h0000_0001, 1'b0});
    single('{OP_MFLO, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b0});

    // Division, then divide-by-zero with identical latency.
    muldiv(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, -1);
    muldiv(OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, -1);

    // SLT to set a known result, then a MULTU with an ignored SUB 5 cycles in.
    single('{OP_SLT, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0});
    muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    single('{OP_MFLO, 5'd0, 32'h0, 32'h0, 32'h0000_0001, 1'b0});

    // Random products and quotients against native 64-bit arithmetic.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      prod = 64'(ra) * 64'(rb);
      muldiv(OP_MULTU, ra, rb, prod[63:32], prod[31:0], -1);
      ra = $urandom;
      rb = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
      muldiv(OP_DIVU, ra, rb, ra % rb, ra / rb, -1);
    end

    // Ensure HI/LO are nonzero so the abort below is observable.
    muldiv(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, -1);

    // Reset 10 cycles into a DIVU: aborted, cleared, no done.
    @(negedge clk);
    op = OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy",   64'(busy), 64'(0));
    check("abort_hi",     64'(hi),   64'(0));
    check("abort_lo",     64'(lo),   64'(0));
    check("abort_result", 64'(res),  64'(0));
    check("abort_zero",   64'(zero), 64'(1));
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", 64'(dcnt), 64'(0));
    m_res = 32'h0; m_z = 1'b1; m_hi = 32'h0; m_lo = 32'h0;

    single('{OP_ADD, 5'd0, 32'd2, 32'd3, 32'd5, 1'b0});

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be even and at least 8.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  operation request; sampled at the rising edge.
REQ-006 ALUOperation  input  4  opcode, sampled with start.
REQ-007 Shamt  input  SHW  shift amount, sampled with start.
REQ-008 A, B  input  WIDTH  operands, sampled with start.
REQ-009 ALUResult  output  WIDTH  registered result.
REQ-010 Zero  output  1  registered flag: 1 when ALUResult == 0.
REQ-011 busy  output  1  multi-cycle operation in progress.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 HI, LO  output  WIDTH  multiply/divide result registers.

Function
REQ-014 Accept: a request is accepted at an edge where start=1, busy=0 and reset=0; start while busy=1 SHALL be ignored with no side effects.
REQ-015 Opcodes: AND 0000 A&B; OR 0001 A|B; NOR 0010 ~(A|B); ADD 0011 A+B (mod 2^WIDTH); SLT 0100 signed A<B gives 1, else 0; LUI 0101 {B[WIDTH/2-1:0], zeros}; SLL 0110 B<<Shamt; SRL 0111 B>>Shamt (logical); SUB 1000 A-B.
REQ-016 MFHI 1011 SHALL give ALUResult=HI; MFLO 1100 SHALL give ALUResult=LO; all other undefined codes SHALL give ALUResult=0.
REQ-017 Single-cycle ops (REQ-015, REQ-016): ALUResult and Zero SHALL update at the accepting edge k; done=1 for the cycle after edge k only; busy stays 0.
REQ-018 MULTU 1001: unsigned A*B; {HI,LO} = 2*WIDTH-bit product.
REQ-019 DIVU 1010: unsigned; LO = quotient, HI = remainder.
REQ-020 Divide by zero (DIVU with B=0): LO = all ones, HI = A; timing is the same as a normal DIVU.
REQ-021 FSM states: IDLE, MUL, DIV.
- IDLE to MUL/DIV on accepting MULTU/DIVU at edge k, iteration counter loaded with WIDTH.
- One iteration per edge, k+1 .. k+WIDTH.
- At edge k+WIDTH: HI/LO written, return to IDLE.
REQ-022 busy SHALL be 1 in the cycles after edges k .. k+WIDTH-1; done=1 for the single cycle after edge k+WIDTH, with busy=0 in that cycle.
REQ-023 A new request SHALL be acceptable in the same cycle done=1 (back-to-back).
REQ-024 MULTU/DIVU SHALL leave ALUResult and Zero unchanged.
REQ-025 HI/LO SHALL be modified only at MULTU/DIVU completion or by reset; intermediate values are never visible on HI/LO.
REQ-026 Operands SHALL be captured at accept; later changes of A/B/Shamt/ALUOperation SHALL not affect a running operation.

Reset
REQ-027 reset=1 at an edge SHALL set: ALUResult 0, Zero 1, busy 0, done 0, HI 0, LO 0, FSM IDLE, counter 0.
REQ-028 reset SHALL override a simultaneous start.
REQ-029 reset mid-MULTU/DIVU SHALL abort the operation with no done pulse.

Structure
REQ-030 Package alu_pkg SHALL hold the opcode constants and the FSM state type.
REQ-031 Sub-module muldiv_unit SHALL hold the iterative shift-add multiplier, the restoring divider, the counter and the FSM; alu_muldiv holds the combinational ops and the output registers.

Verification (WIDTH=32)
REQ-032 ADD A=5, B=0xFFFFFFFB -> ALUResult 0, Zero 1, done pulse one cycle after the accept, busy 0 throughout.
REQ-033 MULTU A=0xFFFFFFFF, B=2 -> busy for 32 cycles, then done, HI=1, LO=0xFFFFFFFE; then MFHI -> ALUResult 1, Zero 0.
REQ-034 DIVU A=100, B=7 -> LO=14, HI=2; then DIVU A=9, B=0 -> LO=0xFFFFFFFF, HI=9, same latency.
REQ-035 SUB issued 5 cycles into a MULTU -> ignored; ALUResult unchanged, single done at cycle 32; SLT A=0xFFFFFFFF, B=1 -> 1.
REQ-036 reset asserted 10 cycles into a DIVU -> busy 0, HI=LO=0, no done; a following ADD 2+3 -> 5.
